// File: rtl/t09_body_scanner.sv
// Sequential snake-body scanner: compares one snapshot entry per clock against the head and
// the apple, then reports sticky collision flags with a one-cycle done pulse.
module t09_body_scanner #(
  parameter int unsigned MAX_LENGTH = 50
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic [MAX_LENGTH*8-1:0] body,
  input  logic [7:0]              curr_length,
  input  logic [7:0]              apple,
  output logic                    busy,
  output logic                    done,
  output logic                    self_hit,
  output logic                    apple_hit,
  output logic                    apple_on_body
);

  localparam int unsigned IdxW   = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam logic [7:0]  MaxLen = 8'(MAX_LENGTH);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          state;
  logic [IdxW-1:0] idx;
  logic [7:0]      len_q;
  logic [7:0]      apple_q;
  logic [7:0]      snap_q [MAX_LENGTH];

  logic [7:0] len_in;
  logic [7:0] entry;
  logic [7:0] head;
  logic       at_last;

  always_comb begin
    len_in  = (curr_length > MaxLen) ? MaxLen : curr_length;
    entry   = snap_q[idx];
    head    = snap_q[0];
    at_last = (8'(idx) == (len_q - 8'd1));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= StIdle;
      idx           <= '0;
      len_q         <= '0;
      apple_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      self_hit      <= 1'b0;
      apple_hit     <= 1'b0;
      apple_on_body <= 1'b0;
      for (int i = 0; i < int'(MAX_LENGTH); i++) snap_q[i] <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < int'(MAX_LENGTH); i++) snap_q[i] <= body[8*i +: 8];
            apple_q       <= apple;
            len_q         <= len_in;
            idx           <= '0;
            self_hit      <= 1'b0;
            apple_hit     <= 1'b0;
            apple_on_body <= 1'b0;
            if (len_in != 8'd0) begin
              state <= StScan;
              busy  <= 1'b1;
            end else begin
              state <= StDone;
            end
          end
        end
        StScan: begin
          if (idx == '0) begin
            if (entry == apple_q) begin
              apple_hit     <= 1'b1;
              apple_on_body <= 1'b1;
            end
          end else begin
            if (entry == head)    self_hit      <= 1'b1;
            if (entry == apple_q) apple_on_body <= 1'b1;
          end
          if (at_last) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        StDone: begin
          // An empty scan enters here with done low and dwells one extra cycle to raise it.
          if (done) begin
            done  <= 1'b0;
            state <= StIdle;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_t09_body_scanner.sv
// Directed and randomised scans against a reference model, with expectations queued at
// stimulus time and retired when done is observed.
module tb_t09_body_scanner;

  localparam int MaxL = 50;
  localparam int BW   = MaxL * 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [BW-1:0] body;
  logic [7:0]    curr_length;
  logic [7:0]    apple;
  logic          busy;
  logic          done;
  logic          self_hit;
  logic          apple_hit;
  logic          apple_on_body;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic self_f;
    logic ahit_f;
    logic aob_f;
    int   lat;
    int   busy_cyc;
  } exp_t;

  exp_t sb[$];

  t09_body_scanner #(.MAX_LENGTH(MaxL)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start        (start),
    .body         (body),
    .curr_length  (curr_length),
    .apple        (apple),
    .busy         (busy),
    .done         (done),
    .self_hit     (self_hit),
    .apple_hit    (apple_hit),
    .apple_on_body(apple_on_body)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [BW-1:0] b, input logic [7:0] cl,
                                 input logic [7:0] ap);
    exp_t       r;
    int         n;
    logic [7:0] e;
    r.self_f = 1'b0;
    r.ahit_f = 1'b0;
    r.aob_f  = 1'b0;
    n = (int'(cl) > MaxL) ? MaxL : int'(cl);
    for (int i = 0; i < n; i++) begin
      e = b[8*i +: 8];
      if (e == ap) r.aob_f = 1'b1;
      if (i == 0 && e == ap) r.ahit_f = 1'b1;
      if (i >= 1 && e == b[7:0]) r.self_f = 1'b1;
    end
    r.lat      = (n == 0) ? 2 : n + 1;
    r.busy_cyc = n;
    return r;
  endfunction

  // poke_at: cycle index at which start is pulsed mid-scan; chg_at: cycle index at which
  // the body bus is replaced by b2. Cycle k is the one following edge T+k-1.
  task automatic run_scan(input string name, input logic [BW-1:0] b, input logic [7:0] cl,
                          input logic [7:0] ap, input int poke_at, input int chg_at,
                          input logic [BW-1:0] b2);
    exp_t e;
    int   cyc;
    int   bcnt;
    sb.push_back(model(b, cl, ap));
    @(negedge clk);
    body = b; curr_length = cl; apple = ap; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    bcnt = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) break;
      start = (cyc == poke_at);
      if (cyc == chg_at) body = b2;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({name, "_latency"}, cyc, e.lat);
    check({name, "_busy_cycles"}, bcnt, e.busy_cyc);
    check({name, "_busy_at_done"}, busy, 1'b0);
    check({name, "_self_hit"}, self_hit, e.self_f);
    check({name, "_apple_hit"}, apple_hit, e.ahit_f);
    check({name, "_apple_on_body"}, apple_on_body, e.aob_f);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 1'b0);
    check({name, "_flags_held"}, {self_hit, apple_hit, apple_on_body},
          {e.self_f, e.ahit_f, e.aob_f});
    repeat (3) begin
      @(negedge clk);
      check({name, "_no_extra_done"}, done, 1'b0);
    end
  endtask

  logic [BW-1:0] b;
  logic [BW-1:0] b2;
  int            dcnt;

  initial begin
    nrst = 1'b0; start = 1'b0; body = '0; curr_length = '0; apple = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_flags", {self_hit, apple_hit, apple_on_body}, 3'b000);
    nrst = 1'b1;

    // No collision; trailing entries equal the head to expose over-scanning.
    b = {MaxL{8'h55}};
    b[7:0] = 8'h55; b[15:8] = 8'h54; b[23:16] = 8'h53;
    run_scan("no_hit", b, 8'd3, 8'h99, 0, 0, b);

    b = '0;
    b[7:0] = 8'h33; b[15:8] = 8'h34; b[23:16] = 8'h44; b[31:24] = 8'h43; b[39:32] = 8'h33;
    run_scan("self_hit", b, 8'd5, 8'h99, 0, 0, b);

    b = {MaxL{8'h21}};
    b[7:0] = 8'h21; b[15:8] = 8'h22;
    run_scan("apple_head", b, 8'd2, 8'h21, 0, 0, b);

    b = {MaxL{8'h77}};
    b[7:0] = 8'h21; b[15:8] = 8'h77;
    run_scan("apple_body", b, 8'd2, 8'h77, 0, 0, b);

    b = {MaxL{8'h10}};
    run_scan("len_zero", b, 8'd0, 8'h10, 0, 0, b);

    // Clamped length: only the last entry (index 49) repeats the head.
    for (int i = 0; i < MaxL; i++) b[8*i +: 8] = 8'(i + 8'h80);
    b[8*(MaxL-1) +: 8] = 8'h80;
    run_scan("len_clamp", b, 8'd200, 8'h01, 0, 0, b);

    // Start pulsed mid-scan and body rewritten; results must follow the original body.
    b = '0;
    b[7:0] = 8'h11; b[15:8] = 8'h12; b[23:16] = 8'h13; b[31:24] = 8'h14;
    b2 = b;
    b2[31:24] = 8'h11; b2[23:16] = 8'h66;
    run_scan("snapshot", b, 8'd4, 8'h13, 1, 2, b2);

    // Reset mid-scan: head equals apple so a flag is already set before reset hits.
    b = '0;
    for (int i = 0; i < 10; i++) b[8*i +: 8] = 8'(8'h40 + i);
    @(negedge clk);
    body = b; curr_length = 8'd10; apple = 8'h40; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_apple_hit", apple_hit, 1'b1);
    check("pre_reset_busy", busy, 1'b1);
    nrst = 1'b0;
    #1;
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_flags", {self_hit, apple_hit, apple_on_body}, 3'b000);
    dcnt = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("aborted_no_done", dcnt, 0);
    b[47:40] = 8'h40;
    run_scan("after_reset", b, 8'd6, 8'h45, 0, 0, b);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < MaxL; i++)
        b[8*i +: 8] = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      run_scan("random", b, 8'($urandom_range(0, 60)),
               {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))}, 0, 0, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t09_body_scanner.md
T09_BODY_SCANNER -- requirements
Module: t09_body_scanner

Interface
REQ-001 SHALL have parameter MAX_LENGTH, default 50, the number of body entries in the packed body bus.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port nrst, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, a request to begin one scan, sampled on the rising edge.
REQ-005 SHALL have port body, input, MAX_LENGTH*8 bits, the packed snake body.
- Entry i occupies bits [8i+7:8i], formatted {x[3:0], y[3:0]}.
- Entry 0 is the head.
REQ-006 SHALL have port curr_length, input, 8 bits, the number of valid entries.
REQ-007 SHALL have port apple, input, 8 bits, the apple coordinate {x[3:0], y[3:0]}.
REQ-008 SHALL have port busy, output, 1 bit, high while a scan is in progress.
REQ-009 SHALL have port done, output, 1 bit, a single-cycle pulse marking that results are valid.
REQ-010 SHALL have port self_hit, output, 1 bit, high when some entry at index 1 or above equals the head.
REQ-011 SHALL have port apple_hit, output, 1 bit, high when the head equals apple.
REQ-012 SHALL have port apple_on_body, output, 1 bit, high when some valid entry, head included, equals apple.

Function
REQ-013 SHALL implement an FSM with states IDLE, SCAN and DONE.
REQ-014 SHALL, in IDLE on an edge with start=1, snapshot body, apple and len, and clear all three flags.
- len = min(curr_length, MAX_LENGTH).
REQ-015 SHALL, on the transition out of IDLE, set index idx to 0 and go to SCAN if len>0, otherwise to DONE.
REQ-016 SHALL, in SCAN, compare exactly one snapshot entry, entry[idx], per clock, then increment idx.
REQ-017 SHALL, when idx==0, set apple_hit and apple_on_body if entry[0]==apple.
REQ-018 SHALL, when idx>=1, set self_hit if entry[idx]==entry[0], and set apple_on_body if entry[idx]==apple.
REQ-019 SHALL make flags sticky within a scan: once set, a flag stays set until the next accepted start or reset.
REQ-020 SHALL go to DONE after the edge that compares idx==len-1.
REQ-021 SHALL, in DONE, drive done=1 for exactly one cycle and then return to IDLE.
REQ-022 SHALL drive busy=1 in SCAN only, and busy=0 in IDLE and DONE.
REQ-023 SHALL meet this latency: with start sampled at edge T, done is high in the cycle following edge T+len (len>=1), or edge T+1 (len=0).
REQ-024 SHALL ignore start while in SCAN or DONE; no restart and no queuing.
REQ-025 SHALL use only the snapshot during a scan; changes on body, apple or curr_length mid-scan have no effect.
REQ-026 SHALL hold self_hit, apple_hit and apple_on_body stable from DONE until the next accepted start.
REQ-027 SHALL size idx to hold MAX_LENGTH-1 and SHALL never index beyond entry len-1.
REQ-028 SHALL be fully synchronous apart from nrst, and SHALL contain no combinational path from start to done.

Reset
REQ-029 SHALL, while nrst=0, force state IDLE, idx=0, busy=0, done=0, self_hit=0, apple_hit=0 and apple_on_body=0, with the snapshot registers cleared to 0.
REQ-030 SHALL, on reset asserted mid-scan, abort the scan with no done pulse, and SHALL accept the first start after nrst deasserts normally.

Verification
REQ-031 SHALL cover a no-collision scan:
- Stimulus: len=3, body entries {0x55, 0x54, 0x53}, apple=0x99, start at edge T.
- Response: busy high 3 cycles; done pulse after edge T+3; all flags 0.
REQ-032 SHALL cover self collision:
- Stimulus: len=5, entries {0x33, 0x34, 0x44, 0x43, 0x33}.
- Response: self_hit=1, apple_hit=0 at done.
REQ-033 SHALL cover apple on head and apple on body:
- Stimulus A: head=0x21, apple=0x21, len=2. Response: apple_hit=1 and apple_on_body=1.
- Stimulus B: apple=entry[1], len=2. Response: apple_hit=0 and apple_on_body=1.
REQ-034 SHALL cover length boundaries:
- Stimulus A: curr_length=0. Response: done one cycle after start, flags 0.
- Stimulus B: curr_length=200 with MAX_LENGTH=50. Response: exactly 50 compares, done after edge T+50.
REQ-035 SHALL cover start while busy and snapshot isolation:
- Stimulus: pulse start at T+1 and change body at T+2 of a len=4 scan.
- Response: a single done after edge T+4; results reflect the body sampled at T.
REQ-036 SHALL cover reset mid-scan:
- Stimulus: assert nrst=0 at T+2 of a len=10 scan, deassert, then start.
- Response: outputs 0 immediately and no done from the aborted scan; the new scan completes correctly.
